// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and counter sizing.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Step counter only has to reach WIDTH-1; keep at least one bit so it stays a legal vector.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin with borrow-out, purely combinational.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first, start/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] result;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             d;
    logic             nb;
    logic             last_step;
    logic             accept;

    full_subtractor_bit u_cell (
        .a    (areg[0]),
        .b    (breg[0]),
        .bin  (borrow),
        .d    (d),
        .bout (nb)
    );

    assign last_step = (count == CW'(WIDTH - 1));
    // A new request is only taken when no operation is in flight.
    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (last_step) state_next = ST_DONE;
            ST_DONE:  state_next = start ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            areg   <= '0;
            breg   <= '0;
            result <= '0;
            borrow <= 1'b0;
            count  <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (accept) begin
            areg   <= a;
            breg   <= b;
            borrow <= bin;
            count  <= '0;
        end else if (state == ST_SHIFT) begin
            areg   <= areg >> 1;
            breg   <= breg >> 1;
            borrow <= nb;
            result <= {d, result[WIDTH-1:1]};
            count  <= count + CW'(1);
            if (last_step) begin
                diff <= {d, result[WIDTH-1:1]};
                bout <= nb;
            end
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of the bit-serial subtractor at WIDTH=4.
module tb_serial_subtractor;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       bout;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // busy and done must never overlap
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((busy && done) !== 1'b0) begin
                errors++;
                $display("FAIL busy_done_overlap: busy=%b done=%b required not both 1", busy, done);
            end
        end
    end

    // Accept edge is the posedge following this call; returns at the next negedge.
    task automatic do_start(input logic [3:0] av, input logic [3:0] bv, input logic bi);
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) until done is high at a negedge; counts busy cycles seen before it.
    task automatic wait_done(output int busy_cnt, output bit ok);
        busy_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, diff, bout} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b diff=%b bout=%b required all 0", busy, done, diff, bout);
        end
        $display("reset: busy=%b done=%b diff=%b bout=%b", busy, done, diff, bout);
    endtask

    task automatic test_basic();
        int  bc;
        bit  ok;
        do_start(4'b0011, 4'b0001, 1'b0);
        wait_done(bc, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout: done=%b required 1", ok); end
        checks++;
        if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d required 4", bc); end
        checks++;
        if ({diff, bout} !== {4'b0010, 1'b0}) begin
            errors++; $display("FAIL basic_result: diff=%b bout=%b required 0010/0", diff, bout);
        end
        @(negedge clk);
        checks++;
        if ({done, diff} !== {1'b0, 4'b0010}) begin
            errors++; $display("FAIL basic_pulse_hold: done=%b diff=%b required 0/0010", done, diff);
        end
        $display("basic: 0011-0001-0 -> diff=%b bout=%b busy_cycles=%0d", diff, bout, bc);
    endtask

    task automatic test_vector(input string name, input logic [3:0] av, input logic [3:0] bv,
                               input logic bi, input logic [3:0] exp_d, input logic exp_b);
        int bc;
        bit ok;
        do_start(av, bv, bi);
        wait_done(bc, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL %s_timeout: done=%b required 1", name, ok); end
        checks++;
        if ({diff, bout} !== {exp_d, exp_b}) begin
            errors++; $display("FAIL %s: diff=%b bout=%b required %b/%b", name, diff, bout, exp_d, exp_b);
        end
        $display("%s: %b-%b-%b -> diff=%b bout=%b", name, av, bv, bi, diff, bout);
    endtask

    task automatic test_start_ignored();
        int bc;
        bit ok;
        int pulses;
        do_start(4'b0111, 4'b0011, 1'b0);
        @(negedge clk);
        a = 4'b0000; b = 4'b0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL ignore_timeout: done=%b required 1", ok); end
        checks++;
        if ({diff, bout} !== {4'b0100, 1'b0}) begin
            errors++; $display("FAIL ignore_result: diff=%b bout=%b required 0100/0", diff, bout);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL ignore_extra_done: got %0d pulses required 0", pulses); end
        $display("start_ignored: diff=%b bout=%b extra_done=%0d", diff, bout, pulses);
    endtask

    task automatic test_reset_abort();
        int bc;
        bit ok;
        int pulses;
        do_start(4'b1100, 4'b0011, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, diff, bout} !== 7'b0) begin
            errors++; $display("FAIL abort_clear: busy=%b done=%b diff=%b bout=%b required all 0", busy, done, diff, bout);
        end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses required 0", pulses); end
        do_start(4'b1010, 4'b0101, 1'b0);
        wait_done(bc, ok);
        checks++;
        if ({ok, diff, bout} !== {1'b1, 4'b0101, 1'b0}) begin
            errors++; $display("FAIL abort_recover: done=%b diff=%b bout=%b required 1/0101/0", ok, diff, bout);
        end
        $display("reset_abort: post-reset 1010-0101 -> diff=%b bout=%b", diff, bout);
    endtask

    task automatic test_back_to_back();
        int bc;
        bit ok;
        @(negedge clk);
        a = 4'b1111; b = 4'b0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done(bc, ok);
        checks++;
        if ({ok, diff, bout} !== {1'b1, 4'b1110, 1'b0}) begin
            errors++; $display("FAIL b2b_first: done=%b diff=%b bout=%b required 1/1110/0", ok, diff, bout);
        end
        a = 4'b0010; b = 4'b0011;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, diff} !== {1'b1, 4'b1110}) begin
            errors++; $display("FAIL b2b_no_bubble: busy=%b diff=%b required 1/1110", busy, diff);
        end
        wait_done(bc, ok);
        checks++;
        if ((bc + 1) !== 5 || ok !== 1'b1) begin
            errors++; $display("FAIL b2b_latency: cycles=%0d done=%b required 5/1", bc + 1, ok);
        end
        checks++;
        if ({diff, bout} !== {4'b1111, 1'b1}) begin
            errors++; $display("FAIL b2b_second: diff=%b bout=%b required 1111/1", diff, bout);
        end
        $display("back_to_back: second 0010-0011 -> diff=%b bout=%b", diff, bout);
    endtask

    task automatic test_random();
        int         bc;
        bit         ok;
        logic [3:0] ra, rb;
        logic       rbi;
        logic [4:0] expv;
        for (int n = 0; n < 20; n++) begin
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rbi = 1'($urandom_range(0, 1));
            expv = {1'b0, ra} - {1'b0, rb} - {4'b0, rbi};
            do_start(ra, rb, rbi);
            wait_done(bc, ok);
            checks++;
            if ({ok, bout, diff} !== {1'b1, expv}) begin
                errors++;
                $display("FAIL random_%0d: %b-%b-%b done=%b diff=%b bout=%b required diff=%b bout=%b",
                         n, ra, rb, rbi, ok, diff, bout, expv[3:0], expv[4]);
            end
            $display("random %0d: %b-%b-%b -> diff=%b bout=%b", n, ra, rb, rbi, diff, bout);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_basic();
        test_vector("underflow", 4'b0001, 4'b0010, 1'b0, 4'b1111, 1'b1);
        test_vector("bin_wrap",  4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1);
        test_vector("bin_exact", 4'b1000, 4'b0111, 1'b1, 4'b0000, 1'b0);
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
